pc_sequencer: RTL and testbench

Program-counter sequencer for the fetch stage. It sits directly downstream of the jump-target lookup table: it consumes the absolute `target` the LUT returns for the current instruction and produces the registered `prog_ctr` that addresses instruction memory. It handles start, stall, absolute jump, conditional branch, halt detection at `HALT_PC`, and a retired-instruction counter that the bench uses for cycle accounting.

---
 rtl/pc_seq_pkg.sv | 8 +
 rtl/sat_counter.sv | 20 ++
 rtl/pc_sequencer.sv | 91 +++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer and its jump-target LUT.
package pc_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;

  localparam int DEF_D       = 12;
  localparam int DEF_HALT_PC = 511;
  localparam int DEF_CW      = 16;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (clr)                cnt_q <= '0;
    else if (en && cnt_q != '1)  cnt_q <= cnt_q + W'(1);
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: start/stall/jump/branch handling, halt detection and
// retired-instruction accounting. All outputs are registered.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int             D       = DEF_D,
  parameter logic [D-1:0]   HALT_PC = D'(DEF_HALT_PC),
  parameter int             CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic          jump_en,
  input  logic          branch_en,
  input  logic          branch_cond,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          taken,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] instr_cnt
);
  pc_state_t    state_q;
  logic [D-1:0] pc_q, pc_inc;
  logic         taken_q, running_q, done_q;
  logic         redirect, cnt_clr, cnt_en;

  assign pc_inc   = pc_q + D'(1);
  assign redirect = jump_en | (branch_en & branch_cond);
  // Every non-stalled RUN cycle retires one instruction, including the halting one.
  assign cnt_en   = (state_q == RUN) & ~stall;
  assign cnt_clr  = start & (state_q != RUN);

  sat_counter #(.W(CW)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (instr_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      taken_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      taken_q <= 1'b0;
      case (state_q)
        IDLE, HALT: if (start) begin
          state_q   <= RUN;
          pc_q      <= '0;
          running_q <= 1'b1;
          done_q    <= 1'b0;
        end
        RUN: if (!stall) begin
          if (redirect && target == HALT_PC) begin
            // Halting is not a fetch redirect, so no flush pulse.
            pc_q      <= HALT_PC;
            state_q   <= HALT;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (redirect) begin
            pc_q    <= target;
            taken_q <= 1'b1;
          end else begin
            pc_q <= pc_inc;
            if (pc_inc == HALT_PC) begin
              state_q   <= HALT;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign prog_ctr = pc_q;
  assign taken    = taken_q;
  assign running  = running_q;
  assign done     = done_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer against a cycle-level behavioural model.
module tb_pc_sequencer;
  localparam int D = 12, CW = 16, HALT = 511;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 0, stall = 0, jump_en = 0, branch_en = 0, branch_cond = 0;
  logic [D-1:0]  target = '0;
  logic [D-1:0]  prog_ctr;
  logic          taken, running, done;
  logic [CW-1:0] instr_cnt;

  logic          s_clr = 0, s_en = 0;
  logic [2:0]    s_cnt;

  int n_vec = 0, n_err = 0;

  // model: 0 = idle, 1 = run, 2 = halt
  int m_st, m_pc, m_cnt;
  bit m_taken;

  always #5 clk = ~clk;

  pc_sequencer #(.D(D), .HALT_PC(D'(HALT)), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .jump_en(jump_en),
    .branch_en(branch_en), .branch_cond(branch_cond), .target(target),
    .prog_ctr(prog_ctr), .taken(taken), .running(running), .done(done),
    .instr_cnt(instr_cnt)
  );

  sat_counter #(.W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .en(s_en), .cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_cnt = 0; m_taken = 0;
  endtask

  task automatic model_edge();
    bit redir;
    redir   = jump_en || (branch_en && branch_cond);
    m_taken = 0;
    if (m_st != 1) begin
      if (start) begin m_st = 1; m_pc = 0; m_cnt = 0; end
    end else if (!stall) begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (redir && int'(target) == HALT) begin
        m_pc = HALT; m_st = 2;
      end else if (redir) begin
        m_pc = int'(target); m_taken = 1;
      end else begin
        m_pc = (m_pc + 1) % (1 << D);
        if (m_pc == HALT) m_st = 2;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},      32'(prog_ctr),  32'(m_pc));
    chk({tag, ".taken"},   32'(taken),     32'(m_taken));
    chk({tag, ".running"}, 32'(running),   32'(m_st == 1));
    chk({tag, ".done"},    32'(done),      32'(m_st == 2));
    chk({tag, ".cnt"},     32'(instr_cnt), 32'(m_cnt));
  endtask

  task automatic drive(input bit st, input bit stl, input bit j, input bit b, input bit c,
                       input int tgt);
    start = st; stall = stl; jump_en = j; branch_en = b; branch_cond = c; target = D'(tgt);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    #2;

    // start, then five sequential steps
    drive(1, 0, 0, 0, 0, 0); step("start");
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("seq");
    chk("seq5.pc", 32'(prog_ctr), 32'd5);
    chk("seq5.cnt", 32'(instr_cnt), 32'd5);

    // jump then taken branch
    drive(0, 0, 1, 0, 0, 'h020); step("j020");
    drive(0, 0, 1, 0, 0, 'h021); step("j021");
    chk("j021.taken", 32'(taken), 32'd1);
    drive(0, 0, 0, 1, 1, 'h01a); step("b01a");
    chk("b01a.pc", 32'(prog_ctr), 32'h01a);
    chk("b01a.taken", 32'(taken), 32'd1);
    drive(0, 0, 0, 0, 0, 0); step("post_b");

    // not-taken branch
    drive(0, 0, 1, 0, 0, 'h030); step("j030");
    drive(0, 0, 0, 1, 0, 'h075); step("bnt");
    chk("bnt.pc", 32'(prog_ctr), 32'h031);
    chk("bnt.taken", 32'(taken), 32'd0);

    // stall with a pending jump
    drive(0, 0, 1, 0, 0, 'h045); step("j045");
    drive(0, 1, 1, 0, 0, 'h099);
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall.pc", 32'(prog_ctr), 32'h045);
    drive(0, 0, 1, 0, 0, 'h099); step("unstall");
    chk("unstall.pc", 32'(prog_ctr), 32'h099);

    // jump to halt, then restart
    drive(0, 0, 1, 0, 0, 'h0f1); step("j0f1");
    drive(0, 0, 1, 0, 0, HALT); step("jhalt");
    chk("jhalt.pc", 32'(prog_ctr), 32'd511);
    chk("jhalt.done", 32'(done), 32'd1);
    chk("jhalt.taken", 32'(taken), 32'd0);
    drive(0, 1, 1, 0, 0, 'h123); step("halt_hold");
    drive(1, 1, 0, 0, 0, 0); step("restart");
    chk("restart.pc", 32'(prog_ctr), 32'd0);
    chk("restart.cnt", 32'(instr_cnt), 32'd0);

    // sequential arrival at halt
    drive(0, 0, 1, 0, 0, 509); step("j509");
    drive(0, 0, 0, 0, 0, 0); step("s510"); step("s511");
    chk("s511.done", 32'(done), 32'd1);
    drive(1, 0, 0, 0, 0, 0); step("restart2");

    // wrap-around above the halt address
    drive(0, 0, 1, 0, 0, 'hffe); step("jffe");
    drive(0, 0, 0, 0, 0, 0); step("sfff"); step("wrap");
    chk("wrap.pc", 32'(prog_ctr), 32'd0);

    // asynchronous reset between edges
    drive(0, 0, 1, 0, 0, 'h0c8); step("j0c8");
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst_n = 1'b1;
    drive(0, 0, 1, 1, 1, 'h077);
    for (int i = 0; i < 3; i++) step("idle_hold");
    chk("idle_hold.pc", 32'(prog_ctr), 32'd0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      int tg;
      tg = ($urandom_range(0, 19) == 0) ? HALT : int'($urandom_range(0, (1 << D) - 1));
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, tg);
      step("rand");
    end
    drive(0, 0, 0, 0, 0, 0);

    // saturation of a narrow counter
    s_clr = 1'b1; @(posedge clk); #1;
    chk("sat.clr", 32'(s_cnt), 32'd0);
    s_clr = 1'b0; s_en = 1'b1;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    chk("sat.max", 32'(s_cnt), 32'd7);
    s_en = 1'b0; s_clr = 1'b1; @(posedge clk); #1;
    chk("sat.reclr", 32'(s_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
